// File: rtl/peripheral_ram_slave_wb.sv
// peripheral_ram_slave_wb: Wishbone B3 slave RAM serving classic cycles and
// registered-feedback bursts (constant and incrementing, linear or wrapped)
// from an internal word array.
// Optional build macro: PERIPHERAL_RAM_WB_ERR_EN -- answers accesses outside the
// memory window with wb_err_o instead of wb_ack_o. Without it the upper address
// bits are ignored and the array aliases across the address space.
module peripheral_ram_slave_wb #(
   parameter int          AW          = 32,
   parameter int          DW          = 32,
   parameter int          DEPTH       = 256,
   parameter int unsigned MEM_BASE    = 0,
   parameter int          WAIT_STATES = 0
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic [AW-1:0]   wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [DW/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic [2:0]      wb_cti_i,
   input  logic [1:0]      wb_bte_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic            wb_rty_o
);

   localparam int            BYTES = DW / 8;
   localparam int            OFF_W = $clog2(BYTES);
   localparam int            IDX_W = $clog2(DEPTH);
   localparam logic [AW-1:0] STEP  = AW'(BYTES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

   state_t          state_q, state_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [3:0]      wait_q, wait_d;

   logic [DW-1:0]   mem [DEPTH];

   logic            req;
   logic            burst_cti;
   logic            raise;
   logic            wr_en;
   logic [AW-1:0]   wrap_mask;
   logic [AW-1:0]   next_addr;
   logic [AW-1:0]   resp_addr;

   assign req       = wb_cyc_i & wb_stb_i;
   assign burst_cti = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);

   function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
      return a[IDX_W+OFF_W-1:OFF_W];
   endfunction

`ifdef PERIPHERAL_RAM_WB_ERR_EN
   // The extra top bit of the difference acts as the borrow for a < base.
   function automatic logic in_window(input logic [AW-1:0] a);
      logic [AW:0] diff;
      diff = {1'b0, a} - {1'b0, AW'(MEM_BASE)};
      return !diff[AW] && (diff[AW-1:0] < AW'(DEPTH * BYTES));
   endfunction
`endif

   // Predict the address of the next burst beat from the current one.
   always_comb begin
      case (wb_bte_i)
         2'b01:   wrap_mask = AW'(4 * BYTES - 1);
         2'b10:   wrap_mask = AW'(8 * BYTES - 1);
         2'b11:   wrap_mask = AW'(16 * BYTES - 1);
         default: wrap_mask = '1;
      endcase
      if (wb_cti_i == 3'b001) begin
         next_addr = addr_q;
      end else begin
         next_addr = (addr_q & ~wrap_mask) | ((addr_q + STEP) & wrap_mask);
      end
   end

   // Next-state logic; 'raise' marks an edge that presents a new response.
   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      dat_d     = dat_q;
      addr_d    = addr_q;
      wait_d    = wait_q;
      raise     = 1'b0;
      resp_addr = wb_adr_i;

      case (state_q)
         S_IDLE: begin
            wait_d = '0;
            if (req) begin
               if (burst_cti) begin
                  state_d = S_BURST;
                  addr_d  = wb_adr_i;
                  raise   = 1'b1;
               end else if (WAIT_STATES == 0) begin
                  state_d = S_ACK;
                  raise   = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
               wait_d  = '0;
            end else if (req) begin
               if (wait_q == 4'(WAIT_STATES - 1)) begin
                  state_d = S_ACK;
                  wait_d  = '0;
                  raise   = 1'b1;
               end else begin
                  wait_d = wait_q + 4'd1;
               end
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         S_BURST: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else if (wb_stb_i) begin
               if (!ack_q) begin
                  raise     = 1'b1;
                  resp_addr = addr_q;
               end else if (!burst_cti) begin
                  state_d = S_IDLE;
               end else begin
                  addr_d    = next_addr;
                  raise     = 1'b1;
                  resp_addr = next_addr;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (raise) begin
`ifdef PERIPHERAL_RAM_WB_ERR_EN
         if (!in_window(resp_addr)) begin
            err_d = 1'b1;
            dat_d = '0;
            if (state_d == S_BURST) begin
               state_d = S_ACK;
            end
         end else begin
            ack_d = 1'b1;
            dat_d = mem[word_idx(resp_addr)];
         end
`else
         ack_d = 1'b1;
         dat_d = mem[word_idx(resp_addr)];
`endif
      end
   end

   // A write lands on the edge that completes an acknowledged beat.
`ifdef PERIPHERAL_RAM_WB_ERR_EN
   assign wr_en = ack_q & req & wb_we_i & in_window(wb_adr_i);
`else
   assign wr_en = ack_q & req & wb_we_i;
`endif

   // Control and response registers with asynchronous active-low reset.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         addr_q  <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         addr_q  <= addr_d;
         wait_q  <= wait_d;
      end
   end

   // Byte-lane writes into the array; contents survive reset.
   always_ff @(posedge wb_clk_i) begin
      if (wr_en) begin
         for (int i = 0; i < BYTES; i++) begin
            if (wb_sel_i[i]) begin
               mem[word_idx(wb_adr_i)][i*8 +: 8] <= wb_dat_i[i*8 +: 8];
            end
         end
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_peripheral_ram_slave_wb.sv
// tb_peripheral_ram_slave_wb: self-checking bench for the Wishbone slave RAM.
// A behavioural memory image (ref_mem) tracks every completed write; burst
// addresses come from plain wrap arithmetic in beat_addr().
module tb_peripheral_ram_slave_wb;

   localparam int WS = 2;

   logic        clk;
   logic        rst_n;
   logic [31:0] wb_adr;
   logic [31:0] wb_dat;
   logic [3:0]  wb_sel;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_stb;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;
   logic [31:0] wb_dat_o;
   logic        wb_ack;
   logic        wb_err;
   logic        wb_rty;

   int          total;
   int          bad;

   logic [31:0] ref_mem [256];
   logic [31:0] wr_data [256];
   logic [3:0]  wr_sel  [256];
   logic [31:0] rd_data [256];
   int          ack_cnt;
   int          first_ack;
   int          last_ack;
   logic        end_ack;

   int          cl_lat;
   logic        cl_ack;
   logic        cl_err;
   logic [31:0] cl_data;
   logic        cl_after;
   logic [31:0] cl_hold;

   peripheral_ram_slave_wb #(
      .AW(32), .DW(32), .DEPTH(256), .MEM_BASE(0), .WAIT_STATES(WS)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wb_adr_i  (wb_adr),
      .wb_dat_i  (wb_dat),
      .wb_sel_i  (wb_sel),
      .wb_we_i   (wb_we),
      .wb_cyc_i  (wb_cyc),
      .wb_stb_i  (wb_stb),
      .wb_cti_i  (wb_cti),
      .wb_bte_i  (wb_bte),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_o  (wb_ack),
      .wb_err_o  (wb_err),
      .wb_rty_o  (wb_rty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Address of beat k of a burst, straight from the wrap rules.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic is_const,
                                             input logic [1:0] bte_v, input int k);
      logic [31:0] span;
      logic [31:0] base;
      if (is_const) return start;
      if (bte_v == 2'b00) return start + 32'(4 * k);
      span = 32'(4 * (2 << bte_v));
      base = start - (start % span);
      return base + ((start % span + 32'(4 * k)) % span);
   endfunction

   task automatic bus_idle();
      wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000; wb_bte = 2'b00;
   endtask

   // Classic single access; records latency, response and data.
   task automatic run_classic(input logic we_v, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we_v; wb_adr = a; wb_dat = d; wb_sel = s;
      wb_cti = 3'b000; wb_bte = 2'b00;
      cl_lat = 0;
      while (!(wb_ack || wb_err) && cl_lat < 40) begin
         @(posedge clk); #1;
         cl_lat++;
      end
      cl_ack  = wb_ack;
      cl_err  = wb_err;
      cl_data = wb_dat_o;
      @(posedge clk); #1;
      cl_after = wb_ack | wb_err;
      cl_hold  = wb_dat_o;
      if (cl_ack && we_v) begin
         for (int i = 0; i < 4; i++) begin
            if (s[i]) ref_mem[a[9:2]][i*8 +: 8] = d[i*8 +: 8];
         end
      end
      bus_idle();
   endtask

   // Registered-feedback burst master; optional two-cycle stb gap after beat stall_after.
   task automatic run_burst(input logic we_v, input logic [31:0] start, input logic is_const,
                            input logic [1:0] bte_v, input int n, input int stall_after);
      int          k;
      int          cyc_cnt;
      int          stall;
      logic        prev;
      logic [31:0] a;
      k = 0; cyc_cnt = 0; stall = 0; prev = 1'b0;
      ack_cnt = 0; first_ack = -1; last_ack = -1;
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we_v; wb_bte = bte_v;
      wb_adr = beat_addr(start, is_const, bte_v, 0);
      wb_dat = wr_data[0]; wb_sel = wr_sel[0];
      wb_cti = (n == 1) ? 3'b111 : (is_const ? 3'b001 : 3'b010);
      while (k < n && cyc_cnt < 4 * n + 40) begin
         @(posedge clk); #1;
         cyc_cnt++;
         if (prev) begin
            if (we_v) begin
               a = beat_addr(start, is_const, bte_v, k);
               for (int i = 0; i < 4; i++) begin
                  if (wr_sel[k][i]) ref_mem[a[9:2]][i*8 +: 8] = wr_data[k][i*8 +: 8];
               end
            end
            k++;
            if (k < n) begin
               wb_adr = beat_addr(start, is_const, bte_v, k);
               wb_dat = wr_data[k]; wb_sel = wr_sel[k];
               wb_cti = (k == n - 1) ? 3'b111 : (is_const ? 3'b001 : 3'b010);
               if (k - 1 == stall_after) begin
                  wb_stb = 1'b0;
                  stall  = 2;
               end
            end
         end else if (stall > 0) begin
            stall--;
            if (stall == 0) wb_stb = 1'b1;
         end
         prev = wb_ack && wb_stb && (k < n);
         if (prev) begin
            rd_data[k] = wb_dat_o;
            ack_cnt++;
            if (first_ack < 0) first_ack = cyc_cnt;
            last_ack = cyc_cnt;
         end
      end
      end_ack = wb_ack;
      bus_idle();
   endtask

   task automatic test_reset();
      total++; if (wb_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack got %b want 0", wb_ack); end
      total++; if (wb_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got %b want 0", wb_err); end
      total++; if (wb_rty !== 1'b0) begin bad++; $display("[TB] FAIL reset_rty got %b want 0", wb_rty); end
      total++; if (wb_dat_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_dat got %h want 0", wb_dat_o); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 256; i++) begin
         wr_data[i] = $urandom;
         wr_sel[i]  = 4'hF;
      end
      run_burst(1'b1, 32'h0, 1'b0, 2'b00, 256, -1);
      total++; if (ack_cnt !== 256) begin bad++; $display("[TB] FAIL fill_acks got %0d want 256", ack_cnt); end
   endtask

   task automatic test_classic();
      run_classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      total++; if (cl_ack !== 1'b1 || cl_lat !== 1 + WS) begin bad++; $display("[TB] FAIL classic_wr_latency got ack=%b lat=%0d want ack=1 lat=%0d", cl_ack, cl_lat, 1 + WS); end
      total++; if (cl_after !== 1'b0) begin bad++; $display("[TB] FAIL classic_ack_width got %b want 0", cl_after); end
      run_classic(1'b0, 32'h10, 32'h0, 4'h0);
      total++; if (cl_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL classic_rd got %h want deadbeef", cl_data); end
      total++; if (cl_hold !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL classic_rd_hold got %h want deadbeef", cl_hold); end
   endtask

   task automatic test_byte_write();
      run_classic(1'b1, 32'h10, 32'h00AA0000, 4'b0100);
      run_classic(1'b0, 32'h10, 32'h0, 4'h0);
      total++; if (cl_data !== 32'hDEAABEEF) begin bad++; $display("[TB] FAIL byte_write got %h want deaabeef", cl_data); end
      run_classic(1'b1, 32'h10, 32'h12345678, 4'b0000);
      run_classic(1'b0, 32'h10, 32'h0, 4'h0);
      total++; if (cl_data !== 32'hDEAABEEF) begin bad++; $display("[TB] FAIL sel_zero got %h want deaabeef", cl_data); end
   endtask

   task automatic test_wrap4();
      logic [31:0] exp [4];
      int          mism;
      exp[0] = ref_mem[14]; exp[1] = ref_mem[15]; exp[2] = ref_mem[12]; exp[3] = ref_mem[13];
      run_burst(1'b0, 32'h38, 1'b0, 2'b01, 4, -1);
      total++; if (ack_cnt !== 4 || last_ack - first_ack !== 3) begin bad++; $display("[TB] FAIL wrap4_acks got cnt=%0d span=%0d want cnt=4 span=3", ack_cnt, last_ack - first_ack); end
      total++; if (end_ack !== 1'b0) begin bad++; $display("[TB] FAIL wrap4_end got ack=%b want 0", end_ack); end
      mism = 0;
      for (int k = 0; k < 4; k++) if (rd_data[k] !== exp[k]) mism++;
      total++; if (mism !== 0) begin bad++; $display("[TB] FAIL wrap4_data got %0d bad words (beat0=%h) want 0 (beat0=%h)", mism, rd_data[0], exp[0]); end
   endtask

   task automatic test_back_to_back_stall();
      logic [31:0] old_lo;
      logic [31:0] old_hi;
      logic [31:0] wbuf [8];
      int          mism;
      old_lo = ref_mem[8'h3F];
      old_hi = ref_mem[8'h48];
      for (int i = 0; i < 8; i++) begin
         wr_data[i] = $urandom; wr_sel[i] = 4'hF; wbuf[i] = wr_data[i];
      end
      run_burst(1'b1, 32'h100, 1'b0, 2'b00, 8, 3);
      total++; if (ack_cnt !== 8) begin bad++; $display("[TB] FAIL stall_acks got %0d want 8", ack_cnt); end
      run_burst(1'b0, 32'hFC, 1'b0, 2'b00, 10, -1);
      mism = 0;
      if (rd_data[0] !== old_lo) mism++;
      if (rd_data[9] !== old_hi) mism++;
      for (int k = 0; k < 8; k++) if (rd_data[k+1] !== wbuf[k]) mism++;
      total++; if (mism !== 0) begin bad++; $display("[TB] FAIL stall_data got %0d bad words want 0", mism); end
   endtask

   task automatic test_cyc_drop();
      logic [31:0] old;
      logic        seen;
      old = ref_mem[8];
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h20;
      wb_dat = ~old; wb_sel = 4'hF; wb_cti = 3'b000;
      @(posedge clk); #1;
      bus_idle();
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (wb_ack || wb_err) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL cyc_drop_ack got %b want 0", seen); end
      run_classic(1'b0, 32'h20, 32'h0, 4'h0);
      total++; if (cl_data !== old) begin bad++; $display("[TB] FAIL cyc_drop_data got %h want %h", cl_data, old); end
   endtask

   task automatic test_window();
      logic [31:0] alias_word;
      alias_word = ref_mem[0];
      run_classic(1'b0, 32'h400, 32'h0, 4'h0);
`ifdef PERIPHERAL_RAM_WB_ERR_EN
      total++; if (cl_err !== 1'b1 || cl_ack !== 1'b0 || cl_lat !== 1 + WS) begin bad++; $display("[TB] FAIL window_err got err=%b ack=%b lat=%0d want err=1 ack=0 lat=%0d", cl_err, cl_ack, cl_lat, 1 + WS); end
      total++; if (cl_data !== 32'h0 || cl_after !== 1'b0) begin bad++; $display("[TB] FAIL window_err_data got dat=%h after=%b want 0/0", cl_data, cl_after); end
`else
      total++; if (cl_ack !== 1'b1 || cl_err !== 1'b0) begin bad++; $display("[TB] FAIL window_alias_ack got ack=%b err=%b want 1/0", cl_ack, cl_err); end
      total++; if (cl_data !== alias_word) begin bad++; $display("[TB] FAIL window_alias_data got %h want %h", cl_data, alias_word); end
`endif
   endtask

   task automatic test_random();
      int          kind;
      int          n;
      int          mism;
      logic        is_const;
      logic [1:0]  bte_v;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] ba;
      for (int it = 0; it < 24; it++) begin
         kind = int'($urandom_range(0, 3));
         a    = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
         if (kind == 0) begin
            d = $urandom;
            run_classic(1'b1, a, d, 4'($urandom_range(0, 15)));
            total++; if (cl_ack !== 1'b1 || cl_lat !== 1 + WS) begin bad++; $display("[TB] FAIL rand_wr it=%0d got ack=%b lat=%0d want ack=1 lat=%0d", it, cl_ack, cl_lat, 1 + WS); end
         end else if (kind == 1) begin
            d = ref_mem[a[9:2]];
            run_classic(1'b0, a, 32'h0, 4'h0);
            total++; if (cl_data !== d) begin bad++; $display("[TB] FAIL rand_rd it=%0d addr=%h got %h want %h", it, a, cl_data, d); end
         end else begin
            is_const = ($urandom_range(0, 3) == 0);
            bte_v    = 2'($urandom_range(0, 3));
            if (is_const) begin
               n = int'($urandom_range(2, 4));
            end else if (bte_v == 2'b00) begin
               n = int'($urandom_range(2, 8));
               a = 32'(int'($urandom_range(0, 32'(256 - n))) * 4);
            end else begin
               n = 2 << bte_v;
            end
            for (int i = 0; i < n; i++) begin
               wr_data[i] = $urandom; wr_sel[i] = 4'($urandom_range(0, 15));
            end
            run_burst(kind == 2, a, is_const, bte_v, n, -1);
            total++; if (ack_cnt !== n) begin bad++; $display("[TB] FAIL rand_burst_acks it=%0d got %0d want %0d", it, ack_cnt, n); end
            if (kind == 3) begin
               mism = 0;
               for (int k = 0; k < n; k++) begin
                  ba = beat_addr(a, is_const, bte_v, k);
                  if (rd_data[k] !== ref_mem[ba[9:2]]) mism++;
               end
               total++; if (mism !== 0) begin bad++; $display("[TB] FAIL rand_burst_data it=%0d got %0d bad words want 0", it, mism); end
            end
         end
      end
   endtask

   task automatic test_readback();
      int mism;
      int first_bad;
      run_burst(1'b0, 32'h0, 1'b0, 2'b00, 256, -1);
      mism = 0; first_bad = -1;
      for (int k = 0; k < 256; k++) begin
         if (rd_data[k] !== ref_mem[k]) begin
            mism++;
            if (first_bad < 0) first_bad = k;
         end
      end
      total++; if (mism !== 0 || ack_cnt !== 256) begin bad++; $display("[TB] FAIL readback got %0d bad words (first %0d) acks=%0d want 0 bad acks=256", mism, first_bad, ack_cnt); end
   endtask

   task automatic test_reset_mid_burst();
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h40;
      wb_cti = 3'b010; wb_bte = 2'b00;
      @(posedge clk); #1;
      total++; if (wb_ack !== 1'b1) begin bad++; $display("[TB] FAIL mid_burst_ack got %b want 1", wb_ack); end
      #3 rst_n = 1'b0;
      #1;
      total++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin bad++; $display("[TB] FAIL async_reset got ack=%b err=%b want 0/0", wb_ack, wb_err); end
      total++; if (wb_dat_o !== 32'h0) begin bad++; $display("[TB] FAIL async_reset_dat got %h want 0", wb_dat_o); end
      bus_idle();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus_idle();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      test_fill();
      test_classic();
      test_byte_write();
      test_wrap4();
      test_back_to_back_stall();
      test_cyc_drop();
      test_window();
      test_random();
      test_readback();
      test_reset_mid_burst();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
